mem_port_arbiter: RTL

Shares the single synchronous data/instruction SRAM port between the IF stage (instruction fetch) and the MEM stage (loads/stores). Each cycle it issues at most one SRAM access. It routes read data back to the owning stage after the SRAM read latency and raises per-stage stall requests toward the pipeline stall controller whenever a stage is denied the port. It sits between the IF/MEM stages and the external SRAM interface, replacing the separate inst/data SRAM ports.

---
 rtl/mem_port_arbiter_pkg.sv | 14 +
 rtl/resp_tag_pipe.sv | 36 +++
 rtl/mem_port_arbiter.sv | 99 +++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants for the IF/MEM single-port SRAM arbiter.
package mem_port_arbiter_pkg;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_DM = 1'b1;

  localparam int unsigned ARB_MAX_STARVE = 4;
  localparam int unsigned SRAM_RD_LAT    = 1;

  function automatic logic [31:0] word_addr(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/resp_tag_pipe.sv
// RD_LAT-deep {valid, owner} shift register that tracks in-flight SRAM reads.
module resp_tag_pipe #(
  parameter int unsigned RD_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  input  logic in_owner,
  output logic out_valid,
  output logic out_owner
);

  logic [RD_LAT-1:0] valid_q, valid_d;
  logic [RD_LAT-1:0] owner_q, owner_d;

  always_comb begin
    valid_d    = valid_q << 1;
    owner_d    = owner_q << 1;
    valid_d[0] = in_valid;
    owner_d[0] = in_owner;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      owner_q <= '0;
    end else begin
      valid_q <= valid_d;
      owner_q <= owner_d;
    end
  end

  assign out_valid = valid_q[RD_LAT-1];
  assign out_owner = owner_q[RD_LAT-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous SRAM port between instruction fetch and load/store,
// routing read data back to the owning stage after RD_LAT cycles.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned RD_LAT     = SRAM_RD_LAT,
  parameter int unsigned MAX_STARVE = ARB_MAX_STARVE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        dm_req,
  input  logic [3:0]  dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic        dm_gnt,
  output logic        dm_rvalid,
  output logic [31:0] dm_rdata,
  output logic        sram_en,
  output logic [3:0]  sram_wen,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_wdata,
  input  logic [31:0] sram_rdata,
  output logic        stallreq_if,
  output logic        stallreq_mem
);

  localparam logic [2:0] STARVE_LIMIT = 3'(MAX_STARVE);

  logic [2:0]  starve_q, starve_d;
  logic [31:0] if_rdata_q, dm_rdata_q;
  logic        if_win, rd_grant, tag_valid, tag_owner;

  always_comb begin
    // MEM normally wins a conflict; IF wins once it has been starved long enough.
    if_win       = if_req & (~dm_req | (starve_q == STARVE_LIMIT));
    if_gnt       = ~rst & if_win;
    dm_gnt       = ~rst & dm_req & ~if_win;
    stallreq_if  = ~rst & if_req & ~if_gnt;
    stallreq_mem = ~rst & dm_req & ~dm_gnt;

    sram_en    = if_gnt | dm_gnt;
    sram_wen   = '0;
    sram_addr  = '0;
    sram_wdata = '0;
    if (if_gnt) begin
      sram_addr = word_addr(if_addr);
    end else if (dm_gnt) begin
      sram_addr  = word_addr(dm_addr);
      sram_wen   = dm_we;
      sram_wdata = dm_wdata;
    end
    rd_grant = if_gnt | (dm_gnt & (dm_we == 4'b0000));

    if (if_gnt || !if_req) begin
      starve_d = '0;
    end else if (starve_q != STARVE_LIMIT) begin
      starve_d = starve_q + 3'd1;
    end else begin
      starve_d = starve_q;
    end
  end

  resp_tag_pipe #(
    .RD_LAT(RD_LAT)
  ) u_resp_tag_pipe (
    .clk      (clk),
    .rst      (rst),
    .in_valid (rd_grant),
    .in_owner (dm_gnt ? OWN_DM : OWN_IF),
    .out_valid(tag_valid),
    .out_owner(tag_owner)
  );

  always_comb begin
    if_rvalid = ~rst & tag_valid & (tag_owner == OWN_IF);
    dm_rvalid = ~rst & tag_valid & (tag_owner == OWN_DM);
    // Bypass the holding register so data is visible in the rvalid cycle itself.
    if_rdata  = rst ? 32'h0 : (if_rvalid ? sram_rdata : if_rdata_q);
    dm_rdata  = rst ? 32'h0 : (dm_rvalid ? sram_rdata : dm_rdata_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q   <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      starve_q <= starve_d;
      if (if_rvalid) if_rdata_q <= sram_rdata;
      if (dm_rvalid) dm_rdata_q <= sram_rdata;
    end
  end

endmodule
